// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI receive path.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int   DATA_W_DEF      = 8;
  localparam int   SYNC_STAGES_DEF = 2;
  localparam int   FIFO_DEPTH_DEF  = 4;
  localparam logic SSEL_IDLE       = 1'b1;

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word fall-through word buffer; a push into a full
// buffer is taken only when a pop frees a slot the same cycle.
module spi_rx_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q[AW-1:0]] = wdata;
    wr_d = wr_q + {{AW{1'b0}}, wr_en};
    rd_d = rd_q + {{AW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/spi_rx_deser.sv
// SPI mode-0 slave receiver: pin sync, MSB-first deserialiser,
// word FIFO with first-of-frame flag and sticky overrun.
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SSEL,
  input  logic              SCK,
  input  logic              MOSI,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_first,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_active,
  output logic              frame_abort,
  output logic              overrun,
  input  logic              clear_overrun
);

  localparam int CW = $clog2(DATA_W);

  logic [SYNC_STAGES:0]   ssel_q, ssel_d;
  logic [SYNC_STAGES:0]   sck_q, sck_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

  state_e            state_q, state_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic              first_q, first_d;
  logic              abort_q, abort_d;
  logic              ovr_q, ovr_d;

  logic              ssel_s, ssel_h, sck_s, sck_h, mosi_s;
  logic              ssel_rise, ssel_fall, sck_rise;
  logic [DATA_W-1:0] shifted;
  logic              push, pop, full, empty;
  logic [DATA_W:0]   rdata;

  assign ssel_d = {ssel_q[SYNC_STAGES-1:0], SSEL};
  assign sck_d  = {sck_q[SYNC_STAGES-1:0], SCK};
  assign mosi_d = {mosi_q[SYNC_STAGES-2:0], MOSI};

  // MOSI tap matches the synced SCK tap so the bit lines up with its edge
  assign ssel_s = ssel_q[SYNC_STAGES-1];
  assign ssel_h = ssel_q[SYNC_STAGES];
  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign sck_h  = sck_q[SYNC_STAGES];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign ssel_rise = ssel_s & ~ssel_h;
  assign ssel_fall = ~ssel_s & ssel_h;
  assign sck_rise  = sck_s & ~sck_h;
  assign shifted   = {shift_q, mosi_s};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    first_d  = first_q;
    abort_d  = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ssel_fall) begin
          state_d  = ACTIVE;
          bitcnt_d = '0;
          shift_d  = '0;
          first_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (ssel_rise) begin
          state_d  = IDLE;
          abort_d  = (bitcnt_q != '0);
          bitcnt_d = '0;
          shift_d  = '0;
        end else if (sck_rise) begin
          shift_d = shifted[DATA_W-2:0];
          if (bitcnt_q == CW'(DATA_W - 1)) begin
            push     = 1'b1;
            bitcnt_d = '0;
            first_d  = 1'b0;
          end else begin
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop   = rx_valid & rx_ready;
  assign ovr_d = (push & full & ~pop) | (ovr_q & ~clear_overrun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_q   <= {(SYNC_STAGES+1){SSEL_IDLE}};
      sck_q    <= '0;
      mosi_q   <= '0;
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      first_q  <= 1'b0;
      abort_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ssel_q   <= ssel_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      first_q  <= first_d;
      abort_q  <= abort_d;
      ovr_q    <= ovr_d;
    end
  end

  spi_rx_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({first_q, shifted}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign rx_valid     = ~empty;
  assign rx_data      = rdata[DATA_W-1:0];
  assign rx_first     = rdata[DATA_W];
  assign frame_active = (state_q == ACTIVE);
  assign frame_abort  = abort_q;
  assign overrun      = ovr_q;

endmodule
